// File: rtl/serial_tx_burst.sv
// serial_tx_burst
//   Serialises up to 2**AddressWidth packed words over one UART-style line,
//   followed by an XOR checksum frame. Word count and baud divisor are
//   latched at start; a one-cycle done pulse marks completion.
//
//   Optional feature macro: SERIAL_TX_PARITY_EN
//     defined   -> even-parity bit after the data bits of every frame
//     undefined -> start, data, stop only
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   ce       start request, accepted when ce=1 and busy=0
//   data     packed words, word i at [i*WordWidth +: WordWidth]
//   length   number of data words minus one
//   divisor  bit period minus one, in clk cycles
//   tx       serial line, idle high
//   busy     burst in progress
//   done     one-cycle pulse at burst completion
module serial_tx_burst #(
  parameter int AddressWidth     = 2,
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ce,
  input  logic [(2**AddressWidth)*WordWidth-1:0] data,
  input  logic [AddressWidth-1:0]               length,
  input  logic [SerialTimerWidth-1:0]           divisor,
  output logic                                  tx,
  output logic                                  busy,
  output logic                                  done
);

  localparam int DataWidth   = (2**AddressWidth) * WordWidth;
  localparam int BitCntWidth = $clog2(WordWidth + 1);
  localparam logic [BitCntWidth-1:0] LastBit = BitCntWidth'(WordWidth - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                      state;
  logic [DataWidth-1:0]        data_s;
  logic [AddressWidth-1:0]     len_s;
  logic [SerialTimerWidth-1:0] div_s;
  logic [SerialTimerWidth-1:0] timer;
  logic [BitCntWidth-1:0]      bit_cnt;
  // One extra bit so index length+1 (the checksum frame) is representable.
  logic [AddressWidth:0]       idx;
  logic [WordWidth-1:0]        shreg;
  logic [WordWidth-1:0]        csum;
`ifdef SERIAL_TX_PARITY_EN
  logic                        par;
`endif

  logic [AddressWidth:0]       next_idx;
  logic [AddressWidth:0]       csum_idx;
  logic                        last_frame;
  logic                        next_is_csum;
  logic [WordWidth-1:0]        next_word;

  always_comb begin
    next_idx     = idx + 1'b1;
    csum_idx     = {1'b0, len_s} + 1'b1;
    last_frame   = (idx == csum_idx);
    next_is_csum = (next_idx == csum_idx);
    next_word    = data_s[next_idx[AddressWidth-1:0]*WordWidth +: WordWidth];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data_s  <= '0;
      len_s   <= '0;
      div_s   <= '0;
      timer   <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      shreg   <= '0;
      csum    <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (ce && !busy) begin
          // Word 0 enters START on the accept edge: checksum starts as word 0.
          data_s  <= data;
          len_s   <= length;
          div_s   <= divisor;
          timer   <= '0;
          bit_cnt <= '0;
          idx     <= '0;
          shreg   <= data[WordWidth-1:0];
          csum    <= data[WordWidth-1:0];
`ifdef SERIAL_TX_PARITY_EN
          par     <= ^data[WordWidth-1:0];
`endif
          tx      <= 1'b0;
          busy    <= 1'b1;
          state   <= START;
        end
      end else if (timer != div_s) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
        case (state)
          START: begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt == LastBit) begin
`ifdef SERIAL_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
`ifdef SERIAL_TX_PARITY_EN
          PARITY: begin
            tx    <= 1'b1;
            state <= STOP;
          end
`endif
          STOP: begin
            if (last_frame) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= next_idx;
              tx    <= 1'b0;
              state <= START;
              if (next_is_csum) begin
                shreg <= csum;
`ifdef SERIAL_TX_PARITY_EN
                par   <= ^csum;
`endif
              end else begin
                shreg <= next_word;
                csum  <= csum ^ next_word;
`ifdef SERIAL_TX_PARITY_EN
                par   <= ^next_word;
`endif
              end
            end
          end
          default: begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_burst.sv
module tb_serial_tx_burst;

  localparam int AW  = 2;
  localparam int WW  = 8;
  localparam int STW = 3;
  localparam int DW  = (2**AW) * WW;
`ifdef SERIAL_TX_PARITY_EN
  localparam int F = WW + 3;
`else
  localparam int F = WW + 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           ce;
  logic [DW-1:0]  data;
  logic [AW-1:0]  length;
  logic [STW-1:0] divisor;
  logic           tx;
  logic           busy;
  logic           done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bit exp_q[$];

  serial_tx_burst #(
    .AddressWidth    (AW),
    .WordWidth       (WW),
    .SerialTimerWidth(STW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .data   (data),
    .length (length),
    .divisor(divisor),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: list of frames (data words then XOR checksum), each expanded
  // to its line bits, each bit repeated for one bit period.
  task automatic build_expected(input logic [DW-1:0] d, input int l, input int dv);
    logic [WW-1:0] frames[$];
    logic [WW-1:0] cs;
    logic [WW-1:0] w;
    bit            bits[$];
    exp_q.delete();
    cs = '0;
    for (int i = 0; i <= l; i++) begin
      w = d[i*WW +: WW];
      frames.push_back(w);
      cs ^= w;
    end
    frames.push_back(cs);
    foreach (frames[f]) begin
      bits.delete();
      bits.push_back(1'b0);
      for (int b = 0; b < WW; b++) bits.push_back(frames[f][b]);
`ifdef SERIAL_TX_PARITY_EN
      bits.push_back(^frames[f]);
`endif
      bits.push_back(1'b1);
      foreach (bits[k])
        for (int r = 0; r <= dv; r++) exp_q.push_back(bits[k]);
    end
  endtask

  // Called away from a clock edge with busy=0. Asserts ce, follows the whole
  // burst cycle by cycle and checks the done cycle.
  task automatic run_burst(input logic [DW-1:0] d, input logic [AW-1:0] l,
                           input logic [STW-1:0] dv, input bit iso, input bit keep_ce);
    int n;
    data    = d;
    length  = l;
    divisor = dv;
    ce      = 1'b1;
    build_expected(d, int'(l), int'(dv));
    n = exp_q.size();
    @(posedge clk);
    #1;
    ce = keep_ce;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check("tx_bit", tx, exp_q[c]);
      check("busy_high", busy, 1);
      check("done_low", done, 0);
      if (iso) begin
        data    = $urandom;
        length  = AW'($urandom);
        divisor = STW'($urandom);
        ce      = 1'($urandom);
      end
      if (c == n - 1) ce = keep_ce;
    end
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("end_tx", tx, 1);
    if (!keep_ce) begin
      @(negedge clk);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_tx", tx, 1);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; data = '0; length = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);

    // Four-word burst, one bit per clock.
    run_burst(32'h44332211, 2'd3, 3'd0, 1'b0, 1'b0);
    // Single word, slow divisor.
    run_burst(32'h000000A5, 2'd0, 3'd7, 1'b0, 1'b0);
    // Full length with input churn and ce pulses while busy.
    run_burst(32'hDEADBEEF, 2'd3, 3'd2, 1'b1, 1'b0);

    // Reset during word 1 data bits (frame 0 occupies cycles 0..19).
    data = 32'h89ABCDEF; length = 2'd3; divisor = 3'd1; ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0;
    repeat (25) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_tx", tx, 1);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mrst_quiet_done", done, 0);
      check("mrst_quiet_tx", tx, 1);
    end
    run_burst(32'h89ABCDEF, 2'd3, 3'd1, 1'b0, 1'b0);

    // Back-to-back with ce held high.
    for (int i = 0; i < 3; i++)
      run_burst($urandom, 2'd1, 3'd1, 1'b0, (i != 2));

    // Randomised bursts, alternating input churn.
    for (int i = 0; i < 8; i++)
      run_burst($urandom, AW'($urandom), STW'($urandom_range(0, 3)), i[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
